// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer code conversions and the default address width
// used by both pointer stages and both synchronizers.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;

  // Binary to reflected Gray code. Callers zero-extend and truncate.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Gray to binary: running XOR prefix starting at the MSB.
  // Zero-extended inputs stay correct because the leading zeros add nothing.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side pointer bundle between the UART writer/RAM and the write-pointer stage.
interface fifo_wptr_full_if import fifo_pkg::*; #(
  parameter int width = FIFO_WIDTH
) ();

  logic             winc;
  logic [width:0]   wq2_rptr;
  logic [width-1:0] waddr;
  logic [width:0]   wptr;
  logic             wen;
  logic             wfull;
  logic             walmost_full;
  logic [width:0]   wfill;
  logic             wovf;

  // Writer / synchronizer side
  modport master (
    output winc, wq2_rptr,
    input  waddr, wptr, wen, wfull, walmost_full, wfill, wovf
  );

  // Pointer stage side
  modport slave (
    input  winc, wq2_rptr,
    output waddr, wptr, wen, wfull, walmost_full, wfill, wovf
  );

endinterface

// File: rtl/fifo_wptr_full_gray2bin.sv
// Combinational Gray-to-binary converter for the synchronized read pointer.
module gray2bin_conv import fifo_pkg::*; #(
  parameter int W = FIFO_WIDTH + 1
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Convert through the shared package function
  always_comb begin
    bin = W'(gray2bin(32'(gray)));
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer stage of the async FIFO: binary/Gray write pointer,
// RAM write address, and registered full / almost-full / fill / overflow status.
module fifo_wptr_full import fifo_pkg::*; #(
  parameter int width        = FIFO_WIDTH,
  parameter int AFULL_MARGIN = 2
) (
  input  logic             wclk,
  input  logic             wrst,
  fifo_wptr_full_if.slave  bus
);

  localparam int             PW        = width + 1;
  // Full when the pointers differ only in the two MSBs of their Gray codes.
  localparam logic [width:0] FULL_MASK = PW'(3) << (width - 1);
  localparam logic [width:0] AFULL_LVL = PW'((1 << width) - AFULL_MARGIN);

  logic [width:0] wbin_q, wbin_d;
  logic [width:0] wptr_q, wptr_d;
  logic [width:0] wfill_q, wfill_d;
  logic [width:0] rbin_sync;
  logic           wfull_q, wfull_d;
  logic           wafull_q, wafull_d;
  logic           wovf_q, wovf_d;
  logic           wacc;

  gray2bin_conv #(.W(PW)) u_rconv (
    .gray (bus.wq2_rptr),
    .bin  (rbin_sync)
  );

  // A write is accepted only while not full; writes into a full FIFO are dropped.
  assign wacc = bus.winc & ~wfull_q;

  // Next pointer and status, all derived from the post-write pointer so the
  // write that fills the FIFO raises wfull on the same edge.
  always_comb begin
    wbin_d   = wbin_q + PW'(wacc);
    wptr_d   = PW'(bin2gray(32'(wbin_d)));
    wfull_d  = (wptr_d == (bus.wq2_rptr ^ FULL_MASK));
    wfill_d  = wbin_d - rbin_sync;
    wafull_d = (wfill_d >= AFULL_LVL);
    wovf_d   = wovf_q | (bus.winc & wfull_q);
  end

  // State registers with synchronous reset discarding all pointer history.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfill_q  <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wfill_q  <= wfill_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  // During reset the enable simply follows winc; the read side is held in
  // reset too, so the RAM contents written then are never observed.
  assign bus.wen          = wrst ? bus.winc : wacc;
  assign bus.waddr        = wbin_q[width-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = wafull_q;
  assign bus.wfill        = wfill_q;
  assign bus.wovf         = wovf_q;

endmodule
